subterranean_din_packer: RTL
============================

// Module: subterranean_din_packer
// PURPOSE
//  Packs a host byte stream into the 32-bit din/din_size/din_last word bus consumed by subterranean_stream.
//  It is the transmitter end of that din bus.
//  Two word slots (assembly + output) sustain 1 byte/cycle with dout_ready held high.
//  Supports short last words, empty messages and optional full-word padding.
// PARAMETERS
//  G_PAD_FULL_LAST  0   1: a message of 4k bytes (k>0) ends with an extra size-0 word with last=1,
//                       and its final full word carries last=0. 0: the final full word carries last=1.
//  G_CNT_WIDTH      16  width of msg_word_cnt.
// PORTS
//  clk           in   1   clock, rising edge
//  arst          in   1   asynchronous reset, active-high
//  bin           in   8   input byte
//  bin_empty     in   1   beat carries no byte; only legal with bin_last=1
//  bin_last      in   1   final beat of message
//  bin_valid     in   1   byte beat valid
//  bin_ready     out  1   byte beat accepted when bin_valid & bin_ready
//  dout          out  32  packed word, first byte in [7:0], unused bytes zero
//  dout_size     out  3   valid bytes in dout, 0..4
//  dout_last     out  1   final word of message
//  dout_valid    out  1   word valid (to core din_valid)
//  dout_ready    in   1   core din_ready
//  msg_word_cnt  out  G_CNT_WIDTH  words handshaken in current message, saturating
//  busy          out  1   any slot occupied or pad pending
// BEHAVIOUR
//  Reset: all registers async-cleared while arst=1.
//   Outputs: dout=0, dout_size=0, dout_last=0, dout_valid=0, msg_word_cnt=0, busy=0.
//   bin_ready=1 after release.
//  Assembly slot: acc[31:0], acc_cnt[2:0], acc_last, acc_closed.
//   Accepted byte is written to acc[8*acc_cnt +: 8], then acc_cnt++.
//  Close: acc closes on acc_cnt becoming 4, or on an accepted bin_last beat.
//   bin_empty=1 beat: closes without writing; acc_cnt is unchanged.
//   Empty message: lone bin_empty|bin_last beat gives size-0 word, last=1.
//  Output slot: registered dout/dout_size/dout_last/dout_valid.
//   out_free = !dout_valid | dout_ready.
//   Closed acc moves to the output slot when out_free. Same edge: acc clears, acc_cnt=0, acc_closed=0.
//  bin_ready = !acc_closed | out_free (combinational path dout_ready->bin_ready permitted).
//   If the accepted beat arrives while the closed acc is moving, the byte lands at acc[7:0] of the fresh word.
//  Latency: byte that closes a word -> dout_valid next cycle.
//  Handshake: dout, dout_size, dout_last stable while dout_valid & !dout_ready. dout_valid is never withdrawn.
//  Padding (G_PAD_FULL_LAST=1): last beat making acc_cnt 4 moves the word with last=0.
//   acc then holds a pad word: closed, cnt 0, last 1, data 0. bin_ready=0 until the pad word moves.
//   A bin_empty last beat on an empty acc is not padded further.
//  msg_word_cnt: +1 on every dout handshake, saturating at all-ones.
//   Cleared on the handshake of a dout_last=1 word, so the cycle after, it reads 0.
//  busy = acc_cnt!=0 | acc_closed | dout_valid.
//  Illegal: bin_empty=1 with bin_last=0 is ignored as a no-op beat (accepted, no state change).
//  Reset mid-message: everything discarded; the next accepted byte starts a new word.
// TESTING
//  T1: 4-byte message 11,22,33,44 with last on 44, dout_ready=1, G_PAD_FULL_LAST=0.
//      -> one word 0x44332211, size 4, last 1; msg_word_cnt returns to 0.
//  T2: 6 bytes 01..06, stall dout_ready low 3 cycles after first word valid.
//      -> 0x04030201/4/0 held stable while stalled, then 0x00000605/2/1.
//      -> bin_ready=0 during the stall once acc is closed.
//  T3: empty message (bin_empty=1, bin_last=1) -> 0x00000000, size 0, last 1.
//      Also bin_empty last after 3 bytes AA,BB,CC -> 0x00CCBBAA, size 3, last 1.
//  T4: G_PAD_FULL_LAST=1, 8 bytes -> three words: size 4 last 0, size 4 last 0, size 0 last 1.
//  T5: 40 back-to-back bytes, dout_ready=1 -> bin_ready constantly 1.
//      -> 10 words, first dout_valid 4 cycles after first byte; only the tenth word has last=1.
//  T6: arst pulse after 2 bytes of a message -> outputs at reset values.
//      -> next bytes 7A,7B (last) give 0x00007B7A, size 2, last 1.

Source files
------------

// File: rtl/subterranean_din_packer.sv
// Packs a host byte stream into 32-bit din words (data/size/last) for subterranean_stream.
// One assembly slot feeds one registered output slot, so 1 byte/cycle is sustained with dout_ready high.
module subterranean_din_packer #(
  parameter int G_PAD_FULL_LAST = 0,
  parameter int G_CNT_WIDTH     = 16
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic [7:0]             bin,
  input  logic                   bin_empty,
  input  logic                   bin_last,
  input  logic                   bin_valid,
  output logic                   bin_ready,
  output logic [31:0]            dout,
  output logic [2:0]             dout_size,
  output logic                   dout_last,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [G_CNT_WIDTH-1:0] msg_word_cnt,
  output logic                   busy
);

  logic [31:0]            r_acc;
  logic [2:0]             r_acc_cnt;
  logic                   r_acc_last;
  logic                   r_acc_closed;
  logic                   r_pad_pend;
  logic [31:0]            r_dout;
  logic [2:0]             r_dout_size;
  logic                   r_dout_last;
  logic                   r_dout_valid;
  logic [G_CNT_WIDTH-1:0] r_msg_cnt;

  logic        w_out_free;
  logic        w_move;
  logic        w_accept;
  logic        w_noop;
  logic [2:0]  w_base_cnt;
  logic [31:0] w_acc_nxt;
  logic [2:0]  w_cnt_nxt;
  logic        w_last_nxt;
  logic        w_closed_nxt;
  logic        w_pad_nxt;

  assign w_out_free = !r_dout_valid || dout_ready;
  assign w_move     = r_acc_closed && w_out_free;
  // While a pad word is queued behind the full word, the acc is spoken for on the move edge.
  assign bin_ready  = (!r_acc_closed || w_out_free) && !r_pad_pend;
  assign w_accept   = bin_valid && bin_ready;
  assign w_noop     = bin_empty && !bin_last;
  assign w_base_cnt = w_move ? 3'd0 : r_acc_cnt;

  always_comb begin
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_acc_cnt;
    w_last_nxt   = r_acc_last;
    w_closed_nxt = r_acc_closed;
    w_pad_nxt    = r_pad_pend;
    if (w_move) begin
      w_acc_nxt    = '0;
      w_cnt_nxt    = 3'd0;
      w_last_nxt   = r_pad_pend;
      w_closed_nxt = r_pad_pend;
      w_pad_nxt    = 1'b0;
    end
    if (w_accept && !w_noop) begin
      if (bin_empty) begin
        w_last_nxt   = 1'b1;
        w_closed_nxt = 1'b1;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (w_base_cnt == 3'(i)) w_acc_nxt[8*i +: 8] = bin;
        end
        w_cnt_nxt    = w_base_cnt + 3'd1;
        w_last_nxt   = bin_last;
        w_closed_nxt = bin_last || (w_base_cnt == 3'd3);
        if ((G_PAD_FULL_LAST != 0) && bin_last && (w_base_cnt == 3'd3)) begin
          w_last_nxt = 1'b0;
          w_pad_nxt  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_acc        <= '0;
      r_acc_cnt    <= 3'd0;
      r_acc_last   <= 1'b0;
      r_acc_closed <= 1'b0;
      r_pad_pend   <= 1'b0;
    end else begin
      r_acc        <= w_acc_nxt;
      r_acc_cnt    <= w_cnt_nxt;
      r_acc_last   <= w_last_nxt;
      r_acc_closed <= w_closed_nxt;
      r_pad_pend   <= w_pad_nxt;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_dout       <= '0;
      r_dout_size  <= 3'd0;
      r_dout_last  <= 1'b0;
      r_dout_valid <= 1'b0;
    end else if (w_move) begin
      r_dout       <= r_acc;
      r_dout_size  <= r_acc_cnt;
      r_dout_last  <= r_acc_last;
      r_dout_valid <= 1'b1;
    end else if (dout_ready) begin
      r_dout_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_msg_cnt <= '0;
    end else if (r_dout_valid && dout_ready) begin
      if (r_dout_last)          r_msg_cnt <= '0;
      else if (r_msg_cnt != '1) r_msg_cnt <= r_msg_cnt + 1'b1;
    end
  end

  assign dout         = r_dout;
  assign dout_size    = r_dout_size;
  assign dout_last    = r_dout_last;
  assign dout_valid   = r_dout_valid;
  assign msg_word_cnt = r_msg_cnt;
  assign busy         = (r_acc_cnt != 3'd0) || r_acc_closed || r_dout_valid;

endmodule
